seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the 8-digit multiplexed 7-segment display between a continuous base source and two timed overlay sources (e.g. alarm banner, mode message).
- Produces the registered 34-bit NUM bus consumed by the display scan driver.
- Fixed-priority, preemptive, hold-timed, with optional blinking per overlay.
- Runs on the 1 MHz system clock.

Parameters:
TICK_DIV, 1000, CLK cycles per millisecond tick
HOLD_MS, 2000, overlay display duration in ms
BLINK_MS, 250, blink half-period in ms (on phase, then off phase)

Ports:
CLK  in  1  system clock, 1 MHz
RST  in  1  asynchronous, active-low reset
BASE_NUM  in  32  base display value, 8 BCD digits, digit0 = [3:0]
REQ1  in  1  overlay-1 request pulse; NUM1 sampled on the same cycle
NUM1  in  32  overlay-1 digits
BLINK1  in  1  overlay-1 blink enable, sampled with REQ1
REQ2  in  1  overlay-2 request pulse (higher priority)
NUM2  in  32  overlay-2 digits
BLINK2  in  1  overlay-2 blink enable, sampled with REQ2
CANCEL  in  1  abort active overlay and clear pending requests
NUM  out  34  display bus; [33:32] always 2'b00
GRANT  out  2  current owner: 0 = base, 1 = overlay1, 2 = overlay2
BUSY  out  1  high while GRANT != 0
DONE  out  2  one-cycle pulse: [0] overlay1 ended, [1] overlay2 ended

Behaviour:
- Reset (RST = 0, asynchronous): state IDLE, NUM = 0, GRANT = 0, BUSY = 0, DONE = 0. Pending flags, shadow registers, tick/hold/blink counters all cleared. A reset mid-overlay discards that overlay with no DONE pulse.
- Shadow capture: a REQx high at a rising edge latches NUMx and BLINKx into shadow x and sets pend_x. This holds in any state.
- States are IDLE, SHOW1 and SHOW2. GRANT and BUSY are registered alongside the state.
  - IDLE:
    - pend2 set -> SHOW2.
    - else pend1 set -> SHOW1.
    - Entering a SHOW state clears that pend flag and restarts the tick, hold and blink counters. Blink phase starts "on".
  - SHOW1:
    - REQ2 or pend2 -> SHOW2 (preemption). The remaining overlay1 time is discarded and DONE[0] pulses.
    - REQ1 -> stay, restart hold and blink with new shadow data; no DONE.
  - SHOW2:
    - REQ1 -> pend1 set; served after SHOW2 ends.
    - REQ2 -> restart as above.
  - Timeout:
    - Hold expires when the hold count reaches HOLD_MS-1 on a tick. The state has then been occupied exactly HOLD_MS*TICK_DIV cycles.
    - At that edge: DONE[x] pulses and the next state follows the IDLE priority rules directly, with no idle cycle if a request is pending. Otherwise the next state is IDLE.
  - CANCEL high at an edge in SHOW state:
    - -> IDLE, DONE[x] pulses, pend1/pend2 cleared.
    - CANCEL wins over a same-cycle REQ, and that REQ is discarded.
    - CANCEL in IDLE clears pending flags only.
- Simultaneous REQ1 and REQ2 in IDLE -> SHOW2; pend1 remains set; SHOW1 follows after SHOW2 ends.
- Counters:
  - The tick counter runs 0..TICK_DIV-1 and wraps, emitting a tick.
  - The blink counter toggles phase every BLINK_MS ticks while the state is SHOW.
- NUM register, one cycle after state/GRANT:
  - IDLE: BASE_NUM, tracking continuously with 1-cycle latency.
  - SHOWx: shadow x data.
  - If shadow blink is set and phase is "off", NUM[31:0] = 32'hFFFF_FFFF, which blanks all digits. This is the decoder default for non-BCD values.
- DONE is never high in two consecutive cycles for the same bit unless the overlay was restarted and ended again.

Test Plan:
(Bench parameters: TICK_DIV = 4, HOLD_MS = 3, BLINK_MS = 1.)
- Reset, BASE_NUM = 32'h1234_5678 -> NUM = 0 during reset; NUM = 34'h0_1234_5678 two edges after RST rises; GRANT = 0.
- REQ1 pulse, NUM1 = 32'h0000_0042, BLINK1 = 0:
  - GRANT = 1 at the next edge; NUM = 42 one cycle later.
  - After 12 cycles in SHOW1: DONE[0] pulses and GRANT = 0.
  - NUM returns to BASE_NUM.
- REQ1 with BLINK1 = 1 -> NUM alternates shadow / 32'hFFFF_FFFF every 4 cycles, starting with shadow. There are 3 phases over the 12-cycle hold.
- REQ2 pulse during SHOW1 -> GRANT = 2, DONE[0] pulses the same edge. Check that SHOW2 lasts 12 cycles, that DONE[1] pulses at its end, and that GRANT then returns to 0, not 1.
- REQ1 and REQ2 on the same cycle -> SHOW2 for 12 cycles, then SHOW1 with no intervening IDLE cycle. DONE[1] pulses at the SHOW2→SHOW1 edge.
- Mid-operation events:
  - CANCEL during SHOW2 with pend1 set -> IDLE, DONE[1] pulses, and SHOW1 never occurs.
  - RST asserted during SHOW1 -> all outputs zero immediately, with no DONE pulse.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Display arbiter for the 8-digit 7-segment scan driver. A continuous base value is
// shown unless one of two timed overlays (overlay 2 has priority) currently owns the bus.
package seg_display_arbiter_pkg;
    typedef struct packed {
        logic [31:0] digits;
        logic        blink;
    } shadow_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW1 = 2'd1,
        SHOW2 = 2'd2
    } state_t;
endpackage

// One overlay source: shadow copy of the requested digits plus its pending flag.
module seg_overlay_slot
    import seg_display_arbiter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        cancel,
    input  logic        clr,
    input  logic [31:0] num,
    input  logic        blink,
    output shadow_t     shadow,
    output logic        pend
);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow <= '0;
            pend   <= 1'b0;
        end else begin
            // A cancel discards a request arriving on the same edge.
            if (req && !cancel)
                shadow <= {num, blink};
            if (cancel || clr)
                pend <= 1'b0;
            else if (req)
                pend <= 1'b1;
        end
    end
endmodule

module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int HOLD_MS  = 2000,
    parameter int BLINK_MS = 250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] BASE_NUM,
    input  logic        REQ1,
    input  logic [31:0] NUM1,
    input  logic        BLINK1,
    input  logic        REQ2,
    input  logic [31:0] NUM2,
    input  logic        BLINK2,
    input  logic        CANCEL,
    output logic [33:0] NUM,
    output logic [1:0]  GRANT,
    output logic        BUSY,
    output logic [1:0]  DONE
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_MS  > 1) ? $clog2(HOLD_MS)  : 1;
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    state_t          state, nxt;
    logic [TW-1:0]   tick_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_on;
    logic            tick, expire, enter;
    logic [1:0]      done_nxt, clr;
    logic [1:0]      req_v, blink_v, pend;
    logic [1:0][31:0] num_v;
    shadow_t [1:0]   shadow;
    shadow_t         sel;
    logic [31:0]     disp;

    assign req_v   = {REQ2, REQ1};
    assign blink_v = {BLINK2, BLINK1};
    assign num_v   = {NUM2, NUM1};

    for (genvar i = 0; i < 2; i++) begin : g_slot
        seg_overlay_slot u_slot (
            .CLK    (CLK),
            .RST    (RST),
            .req    (req_v[i]),
            .cancel (CANCEL),
            .clr    (clr[i]),
            .num    (num_v[i]),
            .blink  (blink_v[i]),
            .shadow (shadow[i]),
            .pend   (pend[i])
        );
    end

    assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
    assign expire = tick && (hold_cnt == HW'(HOLD_MS - 1));

    always_comb begin
        nxt      = state;
        enter    = 1'b0;
        done_nxt = 2'b00;
        case (state)
            IDLE: begin
                if (!CANCEL && pend[1]) begin
                    nxt   = SHOW2;
                    enter = 1'b1;
                end else if (!CANCEL && pend[0]) begin
                    nxt   = SHOW1;
                    enter = 1'b1;
                end
            end
            SHOW1: begin
                if (CANCEL) begin
                    nxt         = IDLE;
                    done_nxt[0] = 1'b1;
                end else if (REQ2 || pend[1]) begin
                    nxt         = SHOW2;
                    enter       = 1'b1;
                    done_nxt[0] = 1'b1;
                end else if (REQ1) begin
                    enter = 1'b1;
                end else if (expire) begin
                    done_nxt[0] = 1'b1;
                    nxt   = pend[1] ? SHOW2 : (pend[0] ? SHOW1 : IDLE);
                    enter = (pend != 2'b00);
                end
            end
            SHOW2: begin
                if (CANCEL) begin
                    nxt         = IDLE;
                    done_nxt[1] = 1'b1;
                end else if (REQ2) begin
                    enter = 1'b1;
                end else if (expire) begin
                    done_nxt[1] = 1'b1;
                    nxt   = pend[1] ? SHOW2 : (pend[0] ? SHOW1 : IDLE);
                    enter = (pend != 2'b00);
                end
            end
            default: nxt = IDLE;
        endcase
        clr[0] = enter && (nxt == SHOW1);
        clr[1] = enter && (nxt == SHOW2);
    end

    // Display value is derived from the current owner, so NUM trails GRANT by a cycle.
    always_comb begin
        sel  = (state == SHOW2) ? shadow[1] : shadow[0];
        disp = BASE_NUM;
        if (state != IDLE)
            disp = (sel.blink && !blink_on) ? 32'hFFFF_FFFF : sel.digits;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            GRANT     <= 2'd0;
            BUSY      <= 1'b0;
            DONE      <= 2'b00;
            NUM       <= '0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else begin
            state <= nxt;
            GRANT <= nxt;
            BUSY  <= (nxt != IDLE);
            DONE  <= done_nxt;
            NUM   <= {2'b00, disp};
            if (enter) begin
                tick_cnt  <= '0;
                hold_cnt  <= '0;
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (state != IDLE && tick) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (blink_cnt == BW'(BLINK_MS - 1)) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with short tick/hold/blink timing.
module tb_seg_display_arbiter;
    localparam logic [31:0] BASE = 32'h1234_5678;
    localparam logic [31:0] BLNK = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] BASE_NUM = BASE;
    logic        REQ1 = 1'b0, BLINK1 = 1'b0, REQ2 = 1'b0, BLINK2 = 1'b0, CANCEL = 1'b0;
    logic [31:0] NUM1 = '0, NUM2 = '0;
    logic [33:0] NUM;
    logic [1:0]  GRANT, DONE;
    logic        BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          r1, b1, r2, c;
        logic [31:0] n1, n2;
        logic [1:0]  g, d;
        logic [31:0] n;
    } vec_t;

    vec_t tbl[$];

    seg_display_arbiter #(.TICK_DIV(4), .HOLD_MS(3), .BLINK_MS(1)) dut (
        .CLK(CLK), .RST(RST), .BASE_NUM(BASE_NUM),
        .REQ1(REQ1), .NUM1(NUM1), .BLINK1(BLINK1),
        .REQ2(REQ2), .NUM2(NUM2), .BLINK2(BLINK2),
        .CANCEL(CANCEL), .NUM(NUM), .GRANT(GRANT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t v(bit r1, bit b1, bit r2, bit c, logic [31:0] n1, logic [31:0] n2,
                               logic [1:0] g, logic [1:0] d, logic [31:0] n);
        vec_t x;
        x.r1 = r1; x.b1 = b1; x.r2 = r2; x.c = c;
        x.n1 = n1; x.n2 = n2; x.g = g; x.d = d; x.n = n;
        return x;
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                              input logic [33:0] n);
        chk({tag, ".grant"}, {32'b0, GRANT}, {32'b0, g});
        chk({tag, ".busy"},  {33'b0, BUSY},  {33'b0, (g != 2'd0)});
        chk({tag, ".done"},  {32'b0, DONE},  {32'b0, d});
        chk({tag, ".num"},   NUM, n);
    endtask

    // Drive one cycle of inputs, take the edge, then check the registered outputs.
    task automatic step(input string tag, input bit r1, input bit b1, input bit r2, input bit c,
                        input logic [31:0] n1, input logic [31:0] n2,
                        input logic [1:0] g, input logic [1:0] d, input logic [31:0] n);
        REQ1 = r1; BLINK1 = b1; REQ2 = r2; CANCEL = c;
        if (r1) NUM1 = n1;
        if (r2) NUM2 = n2;
        cyc();
        REQ1 = 1'b0; REQ2 = 1'b0; CANCEL = 1'b0;
        expect_out(tag, g, d, {2'b00, n});
    endtask

    task automatic idle(input string tag, input int cycles, input logic [1:0] g, input logic [31:0] n);
        for (int i = 0; i < cycles; i++) step(tag, 0, 0, 0, 0, '0, '0, g, 2'b00, n);
    endtask

    initial begin
        // Plain overlay 1: 12-cycle hold, DONE[0] on expiry.
        tbl.push_back(v(1, 0, 0, 0, 32'h42, '0, 2'd0, 2'b00, BASE));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, BASE));
        for (int i = 2; i <= 12; i++) tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, 32'h42));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd0, 2'b01, 32'h42));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd0, 2'b00, BASE));
        // Blinking overlay 1: on, off, on phases of 4 cycles.
        tbl.push_back(v(1, 1, 0, 0, 32'h99, '0, 2'd0, 2'b00, BASE));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, BASE));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, 32'h99));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, BLNK));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd1, 2'b00, 32'h99));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd0, 2'b01, 32'h99));
        tbl.push_back(v(0, 0, 0, 0, '0, '0, 2'd0, 2'b00, BASE));

        // Reset state
        repeat (2) cyc();
        expect_out("rst_hold", 2'd0, 2'b00, 34'h0);
        RST = 1'b1;
        cyc();
        cyc();
        expect_out("rst_rel", 2'd0, 2'b00, {2'b00, BASE});

        foreach (tbl[i]) begin
            step($sformatf("tbl[%0d]", i), tbl[i].r1, tbl[i].b1, tbl[i].r2, tbl[i].c,
                 tbl[i].n1, tbl[i].n2, tbl[i].g, tbl[i].d, tbl[i].n);
        end

        // Preemption of overlay 1 by overlay 2; owner returns to base, not overlay 1.
        step("pre.r1", 1, 0, 0, 0, 32'h11, '0, 2'd0, 2'b00, BASE);
        step("pre.g1", 0, 0, 0, 0, '0, '0, 2'd1, 2'b00, BASE);
        idle("pre.s1", 2, 2'd1, 32'h11);
        step("pre.r2", 0, 0, 1, 0, '0, 32'h22, 2'd2, 2'b01, 32'h11);
        idle("pre.s2", 11, 2'd2, 32'h22);
        step("pre.end", 0, 0, 0, 0, '0, '0, 2'd0, 2'b10, 32'h22);
        idle("pre.base", 3, 2'd0, BASE);

        // Simultaneous requests: overlay 2 then overlay 1 back to back.
        step("sim.req", 1, 0, 1, 0, 32'h33, 32'h44, 2'd0, 2'b00, BASE);
        step("sim.g2", 0, 0, 0, 0, '0, '0, 2'd2, 2'b00, BASE);
        idle("sim.s2", 11, 2'd2, 32'h44);
        step("sim.hand", 0, 0, 0, 0, '0, '0, 2'd1, 2'b10, 32'h44);
        idle("sim.s1", 11, 2'd1, 32'h33);
        step("sim.end", 0, 0, 0, 0, '0, '0, 2'd0, 2'b01, 32'h33);
        idle("sim.base", 2, 2'd0, BASE);

        // Cancel in SHOW2 with overlay 1 pending and a same-cycle REQ2.
        step("can.r2", 0, 0, 1, 0, '0, 32'h55, 2'd0, 2'b00, BASE);
        step("can.g2", 0, 0, 0, 0, '0, '0, 2'd2, 2'b00, BASE);
        step("can.s2", 0, 0, 0, 0, '0, '0, 2'd2, 2'b00, 32'h55);
        step("can.r1", 1, 0, 0, 0, 32'h66, '0, 2'd2, 2'b00, 32'h55);
        step("can.s2b", 0, 0, 0, 0, '0, '0, 2'd2, 2'b00, 32'h55);
        step("can.hit", 0, 0, 1, 1, '0, 32'h77, 2'd0, 2'b10, 32'h55);
        idle("can.after", 20, 2'd0, BASE);

        // Cancel in IDLE drops a pending request before it is served.
        step("ican.r1", 1, 0, 0, 0, 32'h12, '0, 2'd0, 2'b00, BASE);
        step("ican.c", 0, 0, 0, 1, '0, '0, 2'd0, 2'b00, BASE);
        idle("ican.after", 4, 2'd0, BASE);

        // Reset during SHOW1: outputs clear immediately, overlay never resumes.
        step("rmid.r1", 1, 0, 0, 0, 32'h88, '0, 2'd0, 2'b00, BASE);
        step("rmid.g1", 0, 0, 0, 0, '0, '0, 2'd1, 2'b00, BASE);
        idle("rmid.s1", 2, 2'd1, 32'h88);
        RST = 1'b0;
        #1;
        expect_out("rmid.async", 2'd0, 2'b00, 34'h0);
        cyc();
        expect_out("rmid.held", 2'd0, 2'b00, 34'h0);
        RST = 1'b1;
        cyc();
        idle("rmid.after", 14, 2'd0, BASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
